write_back: RTL and testbench

- Fifth pipeline stage. Consumes the memory-access stage's `_pype3` outputs and produces the single register-file write port.
- Load path: waits for the data handshake (`dready_n`), aligns and sign/zero-extends the loaded data, and selects the write-back source.
- Back-pressure: drives `load_stall`, which the pipeline ORs into `keep` so upstream stages hold while a load is outstanding.
- Also flags hung memory accesses (`bus_err`) and counts retired instructions (`retire_cnt`).

---
 rtl/write_back.sv | 171 +++++++++++++++++
 tb/tb_write_back.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back.sv
// Fifth pipeline stage: turns the memory-access stage's results into the single
// register-file write port, waiting on the data bus for loads and flagging hung accesses.
module write_back #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWrite_pype3,
    input  logic [1:0]       MemtoReg_pype3,
    input  logic [4:0]       WReg_pype3,
    input  logic [31:0]      ALU_co_w_pype,
    input  logic [31:0]      PCp4_pype3,
    input  logic [31:0]      mem_data_pype,
    input  logic [31:0]      Instraction_pype3,
    input  logic             dready_n,
    output logic             wb_we,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic             load_stall,
    output logic             bus_err,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int            CW         = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    logic [4:0]    ld_rd;
    logic          ld_regwrite;
    logic [2:0]    ld_funct3;
    logic [1:0]    ld_addr_lo;

    logic          bubble;
    logic          is_load;
    logic [4:0]    sel_rd;
    logic          sel_regwrite;
    logic [2:0]    sel_funct3;
    logic [1:0]    sel_addr_lo;
    logic [31:0]   load_data;
    logic [31:0]   sel_data;
    logic          retire_now;
    logic          write_now;
    logic          timeout;

    function automatic logic [31:0] align_load(
        input logic [31:0] raw,
        input logic [2:0]  funct3,
        input logic [1:0]  lane
    );
        logic [7:0]  byte_val;
        logic [15:0] half_val;
        case (lane)
            2'd0:    byte_val = raw[7:0];
            2'd1:    byte_val = raw[15:8];
            2'd2:    byte_val = raw[23:16];
            default: byte_val = raw[31:24];
        endcase
        half_val = lane[1] ? raw[31:16] : raw[15:0];
        case (funct3)
            3'b000:  return {{24{byte_val[7]}}, byte_val};
            3'b100:  return {24'h0, byte_val};
            3'b001:  return {{16{half_val[15]}}, half_val};
            3'b101:  return {16'h0, half_val};
            default: return raw;
        endcase
    endfunction

    // While waiting, the load's own fields come from the copy taken when it stalled.
    always_comb begin
        bubble  = (Instraction_pype3 == 32'h0);
        is_load = !bubble && (MemtoReg_pype3 == 2'b01);

        if (state == ST_WAIT) begin
            sel_rd       = ld_rd;
            sel_regwrite = ld_regwrite;
            sel_funct3   = ld_funct3;
            sel_addr_lo  = ld_addr_lo;
        end else begin
            sel_rd       = WReg_pype3;
            sel_regwrite = RegWrite_pype3;
            sel_funct3   = Instraction_pype3[14:12];
            sel_addr_lo  = ALU_co_w_pype[1:0];
        end

        load_data = align_load(mem_data_pype, sel_funct3, sel_addr_lo);

        if (state == ST_WAIT) begin
            sel_data = load_data;
        end else begin
            case (MemtoReg_pype3)
                2'b01:   sel_data = load_data;
                2'b10:   sel_data = PCp4_pype3;
                default: sel_data = ALU_co_w_pype;
            endcase
        end

        if (state == ST_WAIT) begin
            retire_now = !dready_n;
        end else begin
            retire_now = !bubble && !(is_load && dready_n);
        end

        write_now  = retire_now && sel_regwrite && (sel_rd != 5'd0);
        timeout    = (state == ST_WAIT) && dready_n && (wait_cnt >= WAIT_LIMIT);
        load_stall = ((state == ST_IDLE) && is_load && dready_n) ||
                     ((state == ST_WAIT) && dready_n && (wait_cnt < WAIT_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            ld_rd       <= '0;
            ld_regwrite <= 1'b0;
            ld_funct3   <= '0;
            ld_addr_lo  <= '0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            bus_err     <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            wb_we <= write_now;
            if (write_now) begin
                wb_addr <= sel_rd;
                wb_data <= sel_data;
            end
            if (retire_now) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            if (timeout) begin
                bus_err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (is_load && dready_n) begin
                        state       <= ST_WAIT;
                        wait_cnt    <= CW'(1);
                        ld_rd       <= WReg_pype3;
                        ld_regwrite <= RegWrite_pype3;
                        ld_funct3   <= Instraction_pype3[14:12];
                        ld_addr_lo  <= ALU_co_w_pype[1:0];
                    end
                end
                ST_WAIT: begin
                    // Data arriving on the limit cycle still completes normally.
                    if (!dready_n || (wait_cnt >= WAIT_LIMIT)) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_back.sv
// Randomized bench for write_back: each instruction is treated as one transaction
// whose stall length, write and counter effects are predicted from the stage's rules.
module tb_write_back;

    localparam int MW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWrite_pype3 = 1'b0;
    logic [1:0]  MemtoReg_pype3 = 2'b00;
    logic [4:0]  WReg_pype3 = 5'd0;
    logic [31:0] ALU_co_w_pype = 32'h0;
    logic [31:0] PCp4_pype3 = 32'h0;
    logic [31:0] mem_data_pype = 32'h0;
    logic [31:0] Instraction_pype3 = 32'h0;
    logic        dready_n = 1'b1;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        load_stall;
    logic        bus_err;
    logic [31:0] retire_cnt;

    write_back #(.MAX_WAIT(MW), .CNT_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .RegWrite_pype3    (RegWrite_pype3),
        .MemtoReg_pype3    (MemtoReg_pype3),
        .WReg_pype3        (WReg_pype3),
        .ALU_co_w_pype     (ALU_co_w_pype),
        .PCp4_pype3        (PCp4_pype3),
        .mem_data_pype     (mem_data_pype),
        .Instraction_pype3 (Instraction_pype3),
        .dready_n          (dready_n),
        .wb_we             (wb_we),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .load_stall        (load_stall),
        .bus_err           (bus_err),
        .retire_cnt        (retire_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int stall_cycles = 0;
    logic stall_chk = 1'b0;

    // Expected DUT state, advanced once per clock by the stimulus task.
    logic        exp_we = 1'b0;
    logic [4:0]  exp_addr = 5'd0;
    logic [31:0] exp_data = 32'h0;
    logic [31:0] exp_cnt = 32'h0;
    logic        exp_err = 1'b0;
    logic        exp_stall = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelData(input logic [1:0] m2r, input logic [2:0] f3,
                                              input logic [1:0] a, input logic [31:0] mem,
                                              input logic [31:0] alu, input logic [31:0] pc4);
        logic [31:0] v;
        if (m2r == 2'b10) return pc4;
        if (m2r != 2'b01) return alu;
        case (f3)
            3'b000: begin
                v = (mem >> (8 * int'(a))) & 32'hFF;
                if (v >= 32'h80) v = v | 32'hFFFFFF00;
                return v;
            end
            3'b100: return (mem >> (8 * int'(a))) & 32'hFF;
            3'b001: begin
                v = (mem >> (16 * int'(a[1]))) & 32'hFFFF;
                if (v >= 32'h8000) v = v | 32'hFFFF0000;
                return v;
            end
            3'b101: return (mem >> (16 * int'(a[1]))) & 32'hFFFF;
            default: return mem;
        endcase
    endfunction

    task automatic modelReset();
        exp_we   = 1'b0;
        exp_addr = 5'd0;
        exp_data = 32'h0;
        exp_cnt  = 32'h0;
        exp_err  = 1'b0;
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b0;
            Instraction_pype3 = 32'h0;
            dready_n = 1'b1;
            exp_stall = 1'b0;
            @(posedge clk);
            modelReset();
        end
    endtask

    // One instruction: a load sees dready_n high for d cycles before data arrives
    // (d > MW means it never arrives). abort_at pulls reset on that cycle of the transaction.
    task automatic applyStimulus(input logic rw, input logic [1:0] m2r, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] pc4,
                                 input logic [31:0] mem, input logic [31:0] instr,
                                 input int d, input int abort_at);
        bit load;
        int last;
        load = (instr != 32'h0) && (m2r == 2'b01);
        last = load ? ((d <= MW) ? d : MW) : 0;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            rst               = (k == abort_at) ? 1'b0 : 1'b1;
            RegWrite_pype3    = rw;
            MemtoReg_pype3    = m2r;
            WReg_pype3        = rd;
            ALU_co_w_pype     = alu;
            PCp4_pype3        = pc4;
            Instraction_pype3 = instr;
            mem_data_pype     = (k == last) ? mem : $urandom;
            dready_n          = load ? (k < d) : 1'($urandom_range(0, 1));
            exp_stall         = load && (k < d) && (k < MW);
            @(posedge clk);
            if (k == abort_at) begin
                modelReset();
                break;
            end
            exp_we = 1'b0;
            if (k == last) begin
                if (load && d > MW) begin
                    exp_err = 1'b1;
                end else if (instr != 32'h0) begin
                    exp_cnt = exp_cnt + 32'd1;
                    if (rw && rd != 5'd0) begin
                        exp_we   = 1'b1;
                        exp_addr = rd;
                        exp_data = modelData(m2r, instr[14:12], alu[1:0], mem, alu, pc4);
                    end
                end
            end
        end
    endtask

    // Single compare process: stall before each edge, registered outputs after it.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (stall_chk) begin
                checkOutput("load_stall", 32'(load_stall), 32'(exp_stall));
                if (load_stall === 1'b1) stall_cycles++;
            end
            @(posedge clk);
            #1;
            checkOutput("wb_we", 32'(wb_we), 32'(exp_we));
            checkOutput("wb_addr", 32'(wb_addr), 32'(exp_addr));
            checkOutput("wb_data", wb_data, exp_data);
            checkOutput("retire_cnt", retire_cnt, exp_cnt);
            checkOutput("bus_err", 32'(bus_err), 32'(exp_err));
        end
    end

    initial begin
        #5000000;
        bad++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int r;
        int d;
        int ab;
        logic [31:0] instr;

        doReset(2);
        stall_chk = 1'b1;
        #1;
        checkOutput("lit_reset_we", 32'(wb_we), 32'h0);
        checkOutput("lit_reset_cnt", retire_cnt, 32'h0);
        checkOutput("lit_reset_err", 32'(bus_err), 32'h0);

        $display("[TB] directed: ALU write");
        stall_cycles = 0;
        applyStimulus(1'b1, 2'b00, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h00000033, 0, -1);
        #1;
        checkOutput("lit_add_we", 32'(wb_we), 32'h1);
        checkOutput("lit_add_addr", 32'(wb_addr), 32'h5);
        checkOutput("lit_add_data", wb_data, 32'h00001234);
        checkOutput("lit_add_cnt", retire_cnt, 32'h1);
        checkOutput("lit_add_stall", 32'(stall_cycles), 32'h0);

        $display("[TB] directed: sub-word loads");
        applyStimulus(1'b1, 2'b01, 5'd4, 32'h00000102, 32'h0, 32'h00800000, 32'h00000003, 0, -1);
        #1;
        checkOutput("lit_lb_data", wb_data, 32'hFFFFFF80);
        applyStimulus(1'b1, 2'b01, 5'd4, 32'h00000102, 32'h0, 32'h00800000, 32'h00004003, 0, -1);
        #1;
        checkOutput("lit_lbu_data", wb_data, 32'h00000080);
        applyStimulus(1'b1, 2'b01, 5'd4, 32'h00000102, 32'h0, 32'hBEEF0000, 32'h00005003, 0, -1);
        #1;
        checkOutput("lit_lhu_data", wb_data, 32'h0000BEEF);

        $display("[TB] directed: delayed word load");
        stall_cycles = 0;
        applyStimulus(1'b1, 2'b01, 5'd7, 32'h00000100, 32'h0, 32'hCAFEBABE, 32'h00002003, 3, -1);
        #1;
        checkOutput("lit_lw_stall", 32'(stall_cycles), 32'd3);
        checkOutput("lit_lw_we", 32'(wb_we), 32'h1);
        checkOutput("lit_lw_data", wb_data, 32'hCAFEBABE);
        checkOutput("lit_lw_cnt", retire_cnt, 32'd5);

        $display("[TB] directed: load timeout");
        stall_cycles = 0;
        applyStimulus(1'b1, 2'b01, 5'd8, 32'h00000100, 32'h0, 32'h12345678, 32'h00002003, 100, -1);
        #1;
        checkOutput("lit_to_stall", 32'(stall_cycles), 32'd16);
        checkOutput("lit_to_err", 32'(bus_err), 32'h1);
        checkOutput("lit_to_we", 32'(wb_we), 32'h0);
        checkOutput("lit_to_cnt", retire_cnt, 32'd5);
        applyStimulus(1'b1, 2'b00, 5'd9, 32'h55, 32'h0, 32'h0, 32'h00000033, 0, -1);
        #1;
        checkOutput("lit_err_sticky", 32'(bus_err), 32'h1);

        $display("[TB] directed: JAL and bubble");
        applyStimulus(1'b1, 2'b10, 5'd1, 32'h0, 32'h104, 32'h0, 32'h0000006F, 0, -1);
        #1;
        checkOutput("lit_jal_data", wb_data, 32'h00000104);
        checkOutput("lit_jal_we", 32'(wb_we), 32'h1);
        applyStimulus(1'b1, 2'b10, 5'd0, 32'h0, 32'h200, 32'h0, 32'h0000006F, 0, -1);
        #1;
        checkOutput("lit_x0_we", 32'(wb_we), 32'h0);
        checkOutput("lit_x0_cnt", retire_cnt, 32'd8);
        applyStimulus(1'b1, 2'b00, 5'd3, 32'h77, 32'h0, 32'h0, 32'h00000000, 0, -1);
        #1;
        checkOutput("lit_bubble_we", 32'(wb_we), 32'h0);
        checkOutput("lit_bubble_cnt", retire_cnt, 32'd8);

        $display("[TB] directed: reset during wait");
        applyStimulus(1'b1, 2'b01, 5'd6, 32'h0, 32'h0, 32'h11111111, 32'h00002003, 10, 2);
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h00000000, 0, -1);
        #1;
        checkOutput("lit_rst_cnt", retire_cnt, 32'h0);
        checkOutput("lit_rst_err", 32'(bus_err), 32'h0);
        checkOutput("lit_rst_we", 32'(wb_we), 32'h0);

        $display("[TB] random phase");
        for (int i = 0; i < 400; i++) begin
            instr = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h1);
            r = $urandom_range(0, 9);
            if (r <= 5)      d = 0;
            else if (r <= 7) d = $urandom_range(1, 4);
            else if (r == 8) d = $urandom_range(MW - 1, MW + 1);
            else             d = $urandom_range(5, MW + 3);
            ab = ($urandom_range(0, 39) == 0) ? $urandom_range(0, 3) : -1;
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                          $urandom, $urandom, $urandom, instr, d, ab);
        end
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h00000000, 0, -1);
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h00000000, 0, -1);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
